// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the icache/dcache memory arbiter:
//   - BUS_NONE/BUS_LOAD/BUS_STORE memory command encoding
//   - TAG_BITS, the memory transaction tag width (tag 0 means "no tag")
//   - mem_owner_t, which requester owns an outstanding tag
package mem_arbiter_pkg;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int TAG_BITS = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_owner_t;

  // Any command other than BUS_NONE is a request for the memory port.
  function automatic logic is_request(input logic [1:0] cmd);
    return (cmd != BUS_NONE);
  endfunction

endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table
// Owner table for outstanding memory load tags: one {valid, owner} entry per
// tag value.
// Ports:
//   clock, reset          core clock, asynchronous active-low reset
//   alloc_en/tag/owner    record a newly accepted load at the next edge
//   lookup_tag            tag of the data returning this cycle
//   lookup_valid/owner    combinational lookup from the registered table
//   free_en               clear the entry at lookup_tag at the next edge
// When the same tag is freed and allocated in one cycle, the allocation wins,
// so the entry ends valid with the new owner.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_BITS = mem_arbiter_pkg::TAG_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [TAG_BITS-1:0] alloc_tag,
  input  mem_owner_t          alloc_owner,
  input  logic [TAG_BITS-1:0] lookup_tag,
  output logic                lookup_valid,
  output mem_owner_t          lookup_owner,
  input  logic                free_en
);

  localparam int DEPTH = 1 << TAG_BITS;

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] owner_r;   // 1 = dcache, 0 = icache
  logic [DEPTH-1:0] owner_s;

  // Lookup of the returning tag; tag 0 never names a transaction.
  always_comb begin
    lookup_valid = 1'b0;
    lookup_owner = OWN_I;
    if (lookup_tag != {TAG_BITS{1'b0}}) begin
      lookup_valid = valid_r[lookup_tag];
      lookup_owner = mem_owner_t'(owner_r[lookup_tag]);
    end else begin
      lookup_valid = 1'b0;
      lookup_owner = OWN_I;
    end
  end

  // Next table contents: allocation takes priority over a same-tag free.
  always_comb begin
    valid_s = valid_r;
    owner_s = owner_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_en && (alloc_tag == TAG_BITS'(i))) begin
        valid_s[i] = 1'b1;
        owner_s[i] = (alloc_owner == OWN_D);
      end else if (free_en && (lookup_tag == TAG_BITS'(i))) begin
        valid_s[i] = 1'b0;
        owner_s[i] = owner_r[i];
      end else begin
        valid_s[i] = valid_r[i];
        owner_s[i] = owner_r[i];
      end
    end
  end

  // Table state register; reset drops all ownership.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= {DEPTH{1'b0}};
      owner_r <= {DEPTH{1'b0}};
    end else begin
      valid_r <= valid_s;
      owner_r <= owner_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the icache and dcache onto the single main-memory port, records
// which side owns each accepted load tag and routes returning data only to
// its owner. The dcache normally wins, but after MAX_D_STREAK consecutive
// accepted dcache grants with the icache waiting, the icache is served.
// Ports:
//   clock, reset                        core clock, async active-low reset
//   icache2mem_command/addr             icache request
//   dcache2mem_command/addr/data        dcache request and store data
//   mem2proc_response                   tag accepted this cycle (0 = rejected)
//   mem2proc_data/tag                   returning data and its tag (0 = none)
//   mem_command/addr/data               request presented to memory
//   mem2icache_response/data/tag        icache view of memory
//   mem2dcache_response/data/tag        dcache view of memory
//   i_outstanding/d_outstanding         loads in flight per side
//   orphan_err                          sticky: data returned on an unowned tag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int TAG_BITS     = mem_arbiter_pkg::TAG_BITS,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          icache2mem_command,
  input  logic [XLEN-1:0]     icache2mem_addr,
  input  logic [1:0]          dcache2mem_command,
  input  logic [XLEN-1:0]     dcache2mem_addr,
  input  logic [63:0]         dcache2mem_data,
  input  logic [TAG_BITS-1:0] mem2proc_response,
  input  logic [63:0]         mem2proc_data,
  input  logic [TAG_BITS-1:0] mem2proc_tag,
  output logic [1:0]          mem_command,
  output logic [XLEN-1:0]     mem_addr,
  output logic [63:0]         mem_data,
  output logic [TAG_BITS-1:0] mem2icache_response,
  output logic [63:0]         mem2icache_data,
  output logic [TAG_BITS-1:0] mem2icache_tag,
  output logic [TAG_BITS-1:0] mem2dcache_response,
  output logic [63:0]         mem2dcache_data,
  output logic [TAG_BITS-1:0] mem2dcache_tag,
  output logic [TAG_BITS-1:0] i_outstanding,
  output logic [TAG_BITS-1:0] d_outstanding,
  output logic                orphan_err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic                i_req_s;
  logic                d_req_s;
  logic                grant_i_s;
  logic                grant_d_s;
  logic                accept_s;
  logic                load_acc_s;
  logic                lookup_valid_s;
  mem_owner_t          lookup_owner_s;
  logic                route_valid_s;
  logic                route_i_s;
  logic                route_d_s;
  logic                orphan_s;
  mem_owner_t          alloc_owner_s;
  logic [STREAK_W-1:0] d_streak_r;
  logic [STREAK_W-1:0] d_streak_s;
  logic [TAG_BITS-1:0] i_cnt_s;
  logic [TAG_BITS-1:0] d_cnt_s;

  // Store data goes straight through; both data buses are qualified by tag.
  assign mem_data        = dcache2mem_data;
  assign mem2icache_data = mem2proc_data;
  assign mem2dcache_data = mem2proc_data;

  // Request decode and grant; requests are masked while reset is held so no
  // command, response or tag leaks out.
  always_comb begin
    i_req_s   = reset && is_request(icache2mem_command);
    d_req_s   = reset && is_request(dcache2mem_command);
    grant_d_s = d_req_s && !(i_req_s && (d_streak_r == STREAK_MAX));
    grant_i_s = i_req_s && !grant_d_s;
    accept_s  = (grant_i_s || grant_d_s) && (mem2proc_response != {TAG_BITS{1'b0}});
  end

  // Memory-side mux and zero-latency acceptance forwarding to the grantee.
  always_comb begin
    mem_command         = BUS_NONE;
    mem_addr            = {XLEN{1'b0}};
    mem2icache_response = {TAG_BITS{1'b0}};
    mem2dcache_response = {TAG_BITS{1'b0}};
    alloc_owner_s       = OWN_I;
    if (grant_d_s) begin
      mem_command         = dcache2mem_command;
      mem_addr            = dcache2mem_addr;
      mem2dcache_response = mem2proc_response;
      alloc_owner_s       = OWN_D;
    end else if (grant_i_s) begin
      mem_command         = icache2mem_command;
      mem_addr            = icache2mem_addr;
      mem2icache_response = mem2proc_response;
      alloc_owner_s       = OWN_I;
    end else begin
      mem_command         = BUS_NONE;
      mem_addr            = {XLEN{1'b0}};
      alloc_owner_s       = OWN_I;
    end
    load_acc_s = accept_s && (mem_command == BUS_LOAD);
  end

  mem_tag_table #(
    .TAG_BITS(TAG_BITS)
  ) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (load_acc_s),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (alloc_owner_s),
    .lookup_tag  (mem2proc_tag),
    .lookup_valid(lookup_valid_s),
    .lookup_owner(lookup_owner_s),
    .free_en     (route_valid_s)
  );

  // Return routing: only the owner of a valid tag sees it; unowned tags are orphans.
  always_comb begin
    route_valid_s  = reset && lookup_valid_s;
    route_i_s      = route_valid_s && (lookup_owner_s == OWN_I);
    route_d_s      = route_valid_s && (lookup_owner_s == OWN_D);
    orphan_s       = reset && (mem2proc_tag != {TAG_BITS{1'b0}}) && !lookup_valid_s;
    mem2icache_tag = route_i_s ? mem2proc_tag : {TAG_BITS{1'b0}};
    mem2dcache_tag = route_d_s ? mem2proc_tag : {TAG_BITS{1'b0}};
  end

  // Starvation counter: counts accepted dcache wins while the icache waits.
  always_comb begin
    if (!i_req_s) begin
      d_streak_s = {STREAK_W{1'b0}};
    end else if (grant_i_s && accept_s) begin
      d_streak_s = {STREAK_W{1'b0}};
    end else if (grant_d_s && accept_s && (d_streak_r != STREAK_MAX)) begin
      d_streak_s = d_streak_r + STREAK_W'(1'b1);
    end else begin
      d_streak_s = d_streak_r;
    end
  end

  // Outstanding-load counters; an issue and a return on one side cancel.
  always_comb begin
    case ({load_acc_s && grant_i_s, route_i_s})
      2'b10:   i_cnt_s = i_outstanding + TAG_BITS'(1'b1);
      2'b01:   i_cnt_s = i_outstanding - TAG_BITS'(1'b1);
      default: i_cnt_s = i_outstanding;
    endcase
    case ({load_acc_s && grant_d_s, route_d_s})
      2'b10:   d_cnt_s = d_outstanding + TAG_BITS'(1'b1);
      2'b01:   d_cnt_s = d_outstanding - TAG_BITS'(1'b1);
      default: d_cnt_s = d_outstanding;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_streak_r    <= {STREAK_W{1'b0}};
      i_outstanding <= {TAG_BITS{1'b0}};
      d_outstanding <= {TAG_BITS{1'b0}};
      orphan_err    <= 1'b0;
    end else begin
      d_streak_r    <= d_streak_s;
      i_outstanding <= i_cnt_s;
      d_outstanding <= d_cnt_s;
      orphan_err    <= orphan_err | orphan_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Table-driven bench for mem_arbiter. Each record is one clock cycle of
// stimulus plus the expected combinational outputs and the expected counter
// values after the clock edge. Expected routed returns go through a
// scoreboard queue: pushed when a cycle is driven, popped and compared when
// the outputs are sampled on the falling edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2mem_command;
  logic [31:0] icache2mem_addr;
  logic [1:0]  dcache2mem_command;
  logic [31:0] dcache2mem_addr;
  logic [63:0] dcache2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  mem_command;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [3:0]  mem2icache_response;
  logic [63:0] mem2icache_data;
  logic [3:0]  mem2icache_tag;
  logic [3:0]  mem2dcache_response;
  logic [63:0] mem2dcache_data;
  logic [3:0]  mem2dcache_tag;
  logic [3:0]  i_outstanding;
  logic [3:0]  d_outstanding;
  logic        orphan_err;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .icache2mem_command(icache2mem_command), .icache2mem_addr(icache2mem_addr),
    .dcache2mem_command(dcache2mem_command), .dcache2mem_addr(dcache2mem_addr),
    .dcache2mem_data(dcache2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem2icache_response(mem2icache_response), .mem2icache_data(mem2icache_data),
    .mem2icache_tag(mem2icache_tag),
    .mem2dcache_response(mem2dcache_response), .mem2dcache_data(mem2dcache_data),
    .mem2dcache_tag(mem2dcache_tag),
    .i_outstanding(i_outstanding), .d_outstanding(d_outstanding),
    .orphan_err(orphan_err)
  );

  typedef struct {
    logic [1:0]  icmd;  logic [31:0] iaddr;
    logic [1:0]  dcmd;  logic [31:0] daddr;
    logic [3:0]  resp;  logic [3:0]  rtag;  logic [63:0] rdata;
    logic [1:0]  ecmd;  logic [31:0] eaddr;
    logic [3:0]  eiresp; logic [3:0] edresp;
    logic [3:0]  eitag;  logic [3:0] edtag;
    logic [3:0]  eiout;  logic [3:0] edout;
  } vec_t;

  typedef struct {
    logic [3:0]  itag;
    logic [3:0]  dtag;
    logic [63:0] data;
  } ret_t;

  vec_t vt[$];
  ret_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc, input logic [31:0] da,
    input logic [3:0] rs, input logic [3:0] rt, input logic [63:0] rd,
    input logic [1:0] ec, input logic [31:0] ea, input logic [3:0] eir, input logic [3:0] edr,
    input logic [3:0] eit, input logic [3:0] edt, input logic [3:0] eio, input logic [3:0] edo);
    vec_t v;
    v.icmd = ic; v.iaddr = ia; v.dcmd = dc; v.daddr = da;
    v.resp = rs; v.rtag = rt; v.rdata = rd;
    v.ecmd = ec; v.eaddr = ea; v.eiresp = eir; v.edresp = edr;
    v.eitag = eit; v.edtag = edt; v.eiout = eio; v.edout = edo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    icache2mem_command = v.icmd;
    icache2mem_addr    = v.iaddr;
    dcache2mem_command = v.dcmd;
    dcache2mem_addr    = v.daddr;
    dcache2mem_data    = {32'hD0D0_0000, v.daddr};
    mem2proc_response  = v.resp;
    mem2proc_tag       = v.rtag;
    mem2proc_data      = v.rdata;
  endtask

  task automatic sb_check(input string nm);
    ret_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'h1, 64'h0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_itag"}, mem2icache_tag, e.itag);
      chk({nm, "_dtag"}, mem2dcache_tag, e.dtag);
      chk({nm, "_idata"}, mem2icache_data, e.data);
      chk({nm, "_ddata"}, mem2dcache_data, e.data);
    end
  endtask

  // One cycle: drive just after a rising edge, check outputs on the falling
  // edge, then check counters just after the next rising edge.
  task automatic run_vec(input vec_t v, input string nm);
    ret_t e;
    drive(v);
    e.itag = v.eitag; e.dtag = v.edtag; e.data = v.rdata;
    sb.push_back(e);
    @(negedge clock);
    chk({nm, "_cmd"},   mem_command, v.ecmd);
    chk({nm, "_addr"},  mem_addr, v.eaddr);
    chk({nm, "_mdata"}, mem_data, {32'hD0D0_0000, v.daddr});
    chk({nm, "_iresp"}, mem2icache_response, v.eiresp);
    chk({nm, "_dresp"}, mem2dcache_response, v.edresp);
    sb_check(nm);
    @(posedge clock);
    #1;
    chk({nm, "_iout"}, i_outstanding, v.eiout);
    chk({nm, "_dout"}, d_outstanding, v.edout);
  endtask

  localparam logic [1:0] N = BUS_NONE;
  localparam logic [1:0] L = BUS_LOAD;
  localparam logic [1:0] S = BUS_STORE;

  initial begin
    vec_t idle;
    idle = mk(N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'h0, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // icache-only load on tag 3, then its return
    vt.push_back(idle);
    vt.push_back(mk(L, 32'h100, N, 32'h0, 4'd3, 4'd0, 64'h0, L, 32'h100, 4'd3, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0));
    vt.push_back(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd3, 64'hDEAD, N, 32'h0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0));
    // both requesting, every request accepted: D,D,D,D,I,D,D,D,D,I
    for (int r = 1; r <= 10; r++) begin
      if (r % 5 == 0)
        vt.push_back(mk(L, 32'h100, S, 32'h200, (r == 5) ? 4'd2 : 4'd4, 4'd0, 64'h0,
                        L, 32'h100, (r == 5) ? 4'd2 : 4'd4, 4'd0, 4'd0, 4'd0, (r == 5) ? 4'd1 : 4'd2, 4'd0));
      else
        vt.push_back(mk(L, 32'h100, S, 32'h200, 4'd1, 4'd0, 64'h0,
                        S, 32'h200, 4'd0, 4'd1, 4'd0, 4'd0, (r < 5) ? 4'd0 : 4'd1, 4'd0));
    end
    vt.push_back(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd2, 64'h22, N, 32'h0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0));
    vt.push_back(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd4, 64'h44, N, 32'h0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0));
    // three accepted D wins, three rejected cycles (streak must hold), one more D, then I
    for (int r = 0; r < 3; r++)
      vt.push_back(mk(L, 32'h100, S, 32'h200, 4'd1, 4'd0, 64'h0, S, 32'h200, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0));
    for (int r = 0; r < 3; r++)
      vt.push_back(mk(L, 32'h100, L, 32'h300, 4'd0, 4'd0, 64'h0, L, 32'h300, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0));
    vt.push_back(mk(L, 32'h100, L, 32'h300, 4'd6, 4'd0, 64'h0, L, 32'h300, 4'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd1));
    vt.push_back(mk(L, 32'h100, L, 32'h300, 4'd8, 4'd0, 64'h0, L, 32'h100, 4'd8, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1));
    vt.push_back(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd6, 64'h1234, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd1, 4'd0));
    vt.push_back(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd8, 64'h5678, N, 32'h0, 4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0));

    // Reset held with requests, an acceptance and a return all presented
    reset = 1'b0;
    drive(mk(L, 32'h100, L, 32'h200, 4'd3, 4'd3, 64'h99, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0));
    #12;
    chk("rst_cmd", mem_command, BUS_NONE);
    chk("rst_iresp", mem2icache_response, 4'd0);
    chk("rst_dresp", mem2dcache_response, 4'd0);
    chk("rst_itag", mem2icache_tag, 4'd0);
    chk("rst_dtag", mem2dcache_tag, 4'd0);
    chk("rst_iout", i_outstanding, 4'd0);
    chk("rst_dout", d_outstanding, 4'd0);
    chk("rst_orphan", orphan_err, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    foreach (vt[k]) run_vec(vt[k], $sformatf("v%0d", k));

    // Same-tag return and re-allocation: tag 7 returns to D while I takes tag 7
    run_vec(mk(N, 32'h0, L, 32'h400, 4'd7, 4'd0, 64'h0, L, 32'h400, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd1), "same_alloc");
    run_vec(mk(L, 32'h140, N, 32'h0, 4'd7, 4'd7, 64'hBEEF, L, 32'h140, 4'd7, 4'd0, 4'd0, 4'd7, 4'd1, 4'd0), "same_swap");
    run_vec(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd7, 64'h77, N, 32'h0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0), "same_ret");
    // Different tags returned and accepted in one cycle
    run_vec(mk(N, 32'h0, L, 32'h500, 4'd9, 4'd0, 64'h0, L, 32'h500, 4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd1), "diff_alloc");
    run_vec(mk(L, 32'h180, N, 32'h0, 4'd10, 4'd9, 64'h99, L, 32'h180, 4'd10, 4'd0, 4'd0, 4'd9, 4'd1, 4'd0), "diff_both");
    run_vec(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd10, 64'hAA, N, 32'h0, 4'd0, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0), "diff_ret");
    // Store acceptance leaves no owner; its tag returning is an orphan
    run_vec(mk(N, 32'h0, S, 32'h200, 4'd5, 4'd0, 64'h0, S, 32'h200, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0), "st_acc");
    chk("st_orphan_pre", orphan_err, 1'b0);
    run_vec(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd5, 64'h55, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), "st_ret");
    chk("st_orphan", orphan_err, 1'b1);
    run_vec(idle, "st_idle");
    chk("st_orphan_sticky", orphan_err, 1'b1);

    // Reset with two loads in flight drops ownership
    run_vec(mk(L, 32'h100, N, 32'h0, 4'd11, 4'd0, 64'h0, L, 32'h100, 4'd11, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0), "mid_i");
    run_vec(mk(N, 32'h0, L, 32'h600, 4'd12, 4'd0, 64'h0, L, 32'h600, 4'd0, 4'd12, 4'd0, 4'd0, 4'd1, 4'd1), "mid_d");
    reset = 1'b0;
    drive(mk(L, 32'h100, L, 32'h600, 4'd3, 4'd11, 64'h11, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0));
    #2;
    chk("mid_rst_cmd", mem_command, BUS_NONE);
    chk("mid_rst_iresp", mem2icache_response, 4'd0);
    chk("mid_rst_dresp", mem2dcache_response, 4'd0);
    chk("mid_rst_itag", mem2icache_tag, 4'd0);
    chk("mid_rst_iout", i_outstanding, 4'd0);
    chk("mid_rst_dout", d_outstanding, 4'd0);
    chk("mid_rst_orphan", orphan_err, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    run_vec(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd11, 64'h11, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), "post_i");
    chk("post_orphan", orphan_err, 1'b1);
    run_vec(mk(N, 32'h0, N, 32'h0, 4'd0, 4'd12, 64'h12, N, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), "post_d");

    chk("sb_drained", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
